mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/arb_pick.sv | 16 +
 rtl/mem_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DefaultAddrW = 12;
  localparam int unsigned DefaultDataW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/arb_pick.sv
// Two-port winner select: a lone requester always wins; on a tie the pointer picks.
module arb_pick (
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,
  output logic grant_o
);

  always_comb begin
    grant_o = req1_i;
    if (req0_i && req1_i) begin
      grant_o = ptr_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a single 1-cycle-latency memory port (IDLE -> ACCESS -> DONE).
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; default is fixed p0 priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic                gnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ptr;
  logic                gnt;
  logic                start;

  assign start = (state_q == IDLE) && (p0_req || p1_req);

`ifdef MEM_ARBITER_RR_EN
  logic ptr_q;

  // Preference moves to the port that did not just finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (state_q == DONE) begin
      ptr_q <= ~gnt_q;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  arb_pick u_arb_pick (
    .req0_i  (p0_req),
    .req1_i  (p1_req),
    .ptr_i   (ptr),
    .grant_o (gnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (p0_req || p1_req) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        gnt_q   <= gnt;
        we_q    <= gnt ? p1_we    : p0_we;
        addr_q  <= gnt ? p1_addr  : p0_addr;
        wdata_q <= gnt ? p1_wdata : p0_wdata;
      end
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    p0_ack    = 1'b0;
    p1_ack    = 1'b0;
    p0_rdata  = '0;
    p1_rdata  = '0;
    if (state_q == ACCESS) begin
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
    if (state_q == DONE) begin
      if (gnt_q) begin
        p1_ack   = 1'b1;
        p1_rdata = mem_rdata;
      end else begin
        p0_ack   = 1'b1;
        p0_rdata = mem_rdata;
      end
    end
  end

endmodule
